// File: rtl/execute_div_mc.sv
// Multi-cycle restoring divider for the execute stage (div, divu, rem, remu).
// Optional macro DIV_FAST_PATH_EN retires trivial divisions straight from IDLE.
package execute_div_mc_pkg;
  localparam int PACK_XLEN = 32;
  localparam int PHY_W     = 6;
  localparam int ROB_W     = 7;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_t;

  typedef struct packed {
    div_op_t div_op;
  } sub_op_t;

  typedef enum logic [3:0] {
    instruction_address_misaligned = 4'd0,
    instruction_access_fault       = 4'd1,
    illegal_instruction            = 4'd2,
    breakpoint                     = 4'd3,
    load_address_misaligned        = 4'd4,
    load_access_fault              = 4'd5,
    store_address_misaligned       = 4'd6,
    store_access_fault             = 4'd7
  } riscv_exception_t;

  typedef struct packed {
    logic                   enable;
    logic                   valid;
    logic [31:0]            pc;
    logic [31:0]            inst;
    sub_op_t                sub_op;
    logic                   rd_enable;
    logic                   need_rename;
    logic [PHY_W-1:0]       rd_phy;
    logic [PACK_XLEN-1:0]   src1_value;
    logic [PACK_XLEN-1:0]   src2_value;
    logic                   has_exception;
    riscv_exception_t       exception_id;
    logic [ROB_W-1:0]       rob_id;
  } issue_execute_pack_t;

  typedef struct packed {
    logic                   enable;
    logic                   valid;
    logic [31:0]            pc;
    logic [31:0]            inst;
    logic                   rd_enable;
    logic                   need_rename;
    logic [PHY_W-1:0]       rd_phy;
    logic [PACK_XLEN-1:0]   rd_value;
    logic                   has_exception;
    riscv_exception_t       exception_id;
    logic [ROB_W-1:0]       rob_id;
  } execute_wb_pack_t;

  typedef struct packed {
    logic                   enable;
    logic [PHY_W-1:0]       phy_id;
    logic [PACK_XLEN-1:0]   value;
  } execute_feedback_channel_t;

  typedef struct packed {
    logic enable;
    logic flush;
  } commit_feedback_pack_t;
endpackage

module execute_div_mc
  import execute_div_mc_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  issue_execute_pack_t       issue_div_fifo_data_out,
  input  logic                      issue_div_fifo_data_out_valid,
  output logic                      issue_div_fifo_pop,
  output execute_wb_pack_t          div_wb_port_data_in,
  output logic                      div_wb_port_we,
  output logic                      div_wb_port_flush,
  output execute_feedback_channel_t div_execute_channel_feedback_pack,
  input  commit_feedback_pack_t     commit_feedback_pack,
  output logic                      div_busy
);
  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  ZERO_X    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES_X    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ONE_X     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  MIN_X     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + ONE_X;
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  issue_execute_pack_t pack_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [XLEN-1:0]     quo_r;
  logic [XLEN-1:0]     rem_r;
  logic [XLEN-1:0]     dvs_r;
  logic                bypass_r;
  logic                dz_r;
  logic                ovf_r;
  logic                neg_q_r;
  logic                neg_r_r;

  logic                commit_flush_s;
  logic                pop_s;
  logic                head_signed_s;
  logic                head_neg_a_s;
  logic                head_neg_b_s;
  logic [XLEN-1:0]     head_abs_a_s;
  logic [XLEN-1:0]     head_abs_b_s;
  logic                head_dz_s;
  logic                head_ovf_s;
  logic                head_bypass_s;
  logic                head_fast_s;
  logic [XLEN-1:0]     step_quo_s;
  logic [XLEN-1:0]     step_rem_s;
  logic [XLEN:0]       trial_s;
  logic                is_rem_s;
  logic [XLEN-1:0]     result_s;
  logic                done_live_s;

  // Decode the fifo head: operand magnitudes, special cases and the pop strobe.
  always_comb begin
    commit_flush_s = commit_feedback_pack.enable & commit_feedback_pack.flush;
    pop_s          = (state_r == S_IDLE) & issue_div_fifo_data_out_valid & ~commit_flush_s & ~rst;
    head_signed_s  = (issue_div_fifo_data_out.sub_op.div_op == DIV_OP_DIV) |
                     (issue_div_fifo_data_out.sub_op.div_op == DIV_OP_REM);
    head_neg_a_s   = head_signed_s & issue_div_fifo_data_out.src1_value[XLEN-1];
    head_neg_b_s   = head_signed_s & issue_div_fifo_data_out.src2_value[XLEN-1];
    head_abs_a_s   = head_neg_a_s ? negate(issue_div_fifo_data_out.src1_value)
                                  : issue_div_fifo_data_out.src1_value;
    head_abs_b_s   = head_neg_b_s ? negate(issue_div_fifo_data_out.src2_value)
                                  : issue_div_fifo_data_out.src2_value;
    head_dz_s      = (issue_div_fifo_data_out.src2_value == ZERO_X);
    head_ovf_s     = head_signed_s & (issue_div_fifo_data_out.src1_value == MIN_X) &
                     (issue_div_fifo_data_out.src2_value == ONES_X);
    head_bypass_s  = ~issue_div_fifo_data_out.enable | ~issue_div_fifo_data_out.valid |
                     issue_div_fifo_data_out.has_exception;
`ifdef DIV_FAST_PATH_EN
    head_fast_s    = head_dz_s | head_ovf_s | (head_abs_a_s < head_abs_b_s);
`else
    head_fast_s    = 1'b0;
`endif
  end

  // Restoring division: BITS_PER_CYCLE shift/compare/subtract steps per clock.
  always_comb begin
    step_quo_s = quo_r;
    step_rem_s = rem_r;
    trial_s    = {(XLEN+1){1'b0}};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      trial_s    = {step_rem_s, step_quo_s[XLEN-1]};
      step_quo_s = {step_quo_s[XLEN-2:0], 1'b0};
      if (trial_s >= {1'b0, dvs_r}) begin
        trial_s       = trial_s - {1'b0, dvs_r};
        step_quo_s[0] = 1'b1;
      end else begin
        step_quo_s[0] = 1'b0;
      end
      step_rem_s = trial_s[XLEN-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a commit flush overrides everything.
  always_comb begin
    state_next_s = state_r;
    if (commit_flush_s) begin
      state_next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            state_next_s = (head_bypass_s | head_fast_s) ? S_DONE : S_CALC;
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_CALC:  state_next_s = (cnt_r == LAST_ITER) ? S_DONE : S_CALC;
        S_DONE:  state_next_s = S_IDLE;
        default: state_next_s = S_IDLE;
      endcase
    end
  end

  // Operand latch on pop and iteration update while calculating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_r   <= '0;
      cnt_r    <= CNT_ZERO;
      quo_r    <= ZERO_X;
      rem_r    <= ZERO_X;
      dvs_r    <= ZERO_X;
      bypass_r <= 1'b0;
      dz_r     <= 1'b0;
      ovf_r    <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
    end else if (pop_s) begin
      pack_r   <= issue_div_fifo_data_out;
      cnt_r    <= CNT_ZERO;
      bypass_r <= head_bypass_s;
      dz_r     <= head_dz_s;
      ovf_r    <= head_ovf_s;
      neg_q_r  <= head_neg_a_s ^ head_neg_b_s;
      neg_r_r  <= head_neg_a_s;
      dvs_r    <= head_abs_b_s;
      // Fast path leaves quotient 0 and the dividend magnitude as remainder.
      if (head_bypass_s) begin
        quo_r <= ZERO_X;
        rem_r <= ZERO_X;
      end else if (head_fast_s) begin
        quo_r <= ZERO_X;
        rem_r <= head_abs_a_s;
      end else begin
        quo_r <= head_abs_a_s;
        rem_r <= ZERO_X;
      end
    end else if (state_r == S_CALC) begin
      quo_r <= step_quo_s;
      rem_r <= step_rem_s;
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Final result with sign correction and the divide-by-zero / overflow rules.
  always_comb begin
    is_rem_s = (pack_r.sub_op.div_op == DIV_OP_REM) | (pack_r.sub_op.div_op == DIV_OP_REMU);
    result_s = ZERO_X;
    if (bypass_r) begin
      result_s = ZERO_X;
    end else if (dz_r) begin
      result_s = is_rem_s ? pack_r.src1_value : ONES_X;
    end else if (ovf_r) begin
      result_s = is_rem_s ? ZERO_X : pack_r.src1_value;
    end else if (is_rem_s) begin
      result_s = neg_r_r ? negate(rem_r) : rem_r;
    end else begin
      result_s = neg_q_r ? negate(quo_r) : quo_r;
    end
  end

  // Outputs: writeback and bypass are live only in an unflushed DONE cycle.
  always_comb begin
    done_live_s        = (state_r == S_DONE) & ~commit_flush_s;
    issue_div_fifo_pop = pop_s;
    div_wb_port_we     = done_live_s;
    div_wb_port_flush  = commit_flush_s;
    div_busy           = (state_r != S_IDLE);

    div_wb_port_data_in               = '0;
    div_wb_port_data_in.enable        = done_live_s & pack_r.enable;
    div_wb_port_data_in.valid         = pack_r.valid;
    div_wb_port_data_in.pc            = pack_r.pc;
    div_wb_port_data_in.inst          = pack_r.inst;
    div_wb_port_data_in.rd_enable     = pack_r.rd_enable;
    div_wb_port_data_in.need_rename   = pack_r.need_rename;
    div_wb_port_data_in.rd_phy        = pack_r.rd_phy;
    div_wb_port_data_in.rd_value      = result_s;
    div_wb_port_data_in.has_exception = pack_r.has_exception;
    div_wb_port_data_in.exception_id  = pack_r.exception_id;
    div_wb_port_data_in.rob_id        = pack_r.rob_id;

    div_execute_channel_feedback_pack        = '0;
    div_execute_channel_feedback_pack.enable = done_live_s & pack_r.valid & pack_r.rd_enable &
                                               pack_r.need_rename & ~pack_r.has_exception;
    div_execute_channel_feedback_pack.phy_id = pack_r.rd_phy;
    div_execute_channel_feedback_pack.value  = result_s;
  end
endmodule

// File: tb/tb_execute_div_mc.sv
// Directed, table-driven bench for execute_div_mc (BITS_PER_CYCLE 1 and 4 instances).
module tb_execute_div_mc;
  import execute_div_mc_pkg::*;

`ifdef DIV_FAST_PATH_EN
  localparam int FP1 = 1;
  localparam int FP4 = 1;
`else
  localparam int FP1 = 33;
  localparam int FP4 = 9;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  issue_execute_pack_t       in_pack;
  logic                      valid1, valid4;
  commit_feedback_pack_t     commit;
  logic                      pop1, we1, flush1, busy1;
  logic                      pop4, we4, flush4, busy4;
  execute_wb_pack_t          wb1, wb4;
  execute_feedback_channel_t fb1, fb4;

  execute_div_mc #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst),
    .issue_div_fifo_data_out(in_pack), .issue_div_fifo_data_out_valid(valid1),
    .issue_div_fifo_pop(pop1), .div_wb_port_data_in(wb1), .div_wb_port_we(we1),
    .div_wb_port_flush(flush1), .div_execute_channel_feedback_pack(fb1),
    .commit_feedback_pack(commit), .div_busy(busy1)
  );

  execute_div_mc #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst),
    .issue_div_fifo_data_out(in_pack), .issue_div_fifo_data_out_valid(valid4),
    .issue_div_fifo_pop(pop4), .div_wb_port_data_in(wb4), .div_wb_port_we(we4),
    .div_wb_port_flush(flush4), .div_execute_channel_feedback_pack(fb4),
    .commit_feedback_pack(commit), .div_busy(busy4)
  );

  typedef struct {
    string       name;
    div_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic        exc;
    logic        rd_en;
    logic [5:0]  phy;
    logic [31:0] exp_val;
    logic        chk_val;
    int          exp_lat;
    logic        exp_fb;
  } vec_t;

  int   n_chk = 0;
  int   n_err = 0;
  vec_t vecs[$];

  function automatic vec_t mkv(input string name, input div_op_t op, input logic [31:0] a,
                               input logic [31:0] b, input logic exc, input logic rd_en,
                               input logic [5:0] phy, input logic [31:0] exp_val,
                               input logic chk_val, input int exp_lat, input logic exp_fb);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.exc = exc; v.rd_en = rd_en;
    v.phy = phy; v.exp_val = exp_val; v.chk_val = chk_val; v.exp_lat = exp_lat;
    v.exp_fb = exp_fb;
    return v;
  endfunction

  function automatic issue_execute_pack_t mk_pack(input vec_t v);
    issue_execute_pack_t p;
    p = '0;
    p.enable        = 1'b1;
    p.valid         = 1'b1;
    p.pc            = 32'h0000_1000 + {26'd0, v.phy};
    p.inst          = 32'h0200_4033;
    p.sub_op.div_op = v.op;
    p.rd_enable     = v.rd_en;
    p.need_rename   = 1'b1;
    p.rd_phy        = v.phy;
    p.src1_value    = v.a;
    p.src2_value    = v.b;
    p.has_exception = v.exc;
    p.exception_id  = v.exc ? illegal_instruction : instruction_address_misaligned;
    p.rob_id        = {1'b0, v.phy};
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the writeback cycle.
  task automatic run_op(input vec_t v, input logic four);
    issue_execute_pack_t p;
    execute_wb_pack_t    wb;
    execute_feedback_channel_t fb;
    int lat;
    p = mk_pack(v);
    in_pack = p;
    if (four) valid4 = 1'b1; else valid1 = 1'b1;
    #1;
    check({v.name, " pop"}, {31'd0, four ? pop4 : pop1}, 32'd1);
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    valid4 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if ((four ? we4 : we1) === 1'b1) begin
        lat = c;
        break;
      end
    end
    wb = four ? wb4 : wb1;
    fb = four ? fb4 : fb1;
    check({v.name, " latency"}, lat, v.exp_lat);
    check({v.name, " wb.enable"}, {31'd0, wb.enable}, 32'd1);
    check({v.name, " wb.rd_phy"}, {26'd0, wb.rd_phy}, {26'd0, v.phy});
    check({v.name, " wb.pc"}, wb.pc, p.pc);
    check({v.name, " wb.has_exception"}, {31'd0, wb.has_exception}, {31'd0, v.exc});
    check({v.name, " wb.exception_id"}, {28'd0, wb.exception_id}, {28'd0, p.exception_id});
    check({v.name, " fb.enable"}, {31'd0, fb.enable}, {31'd0, v.exp_fb});
    if (v.chk_val) begin
      check({v.name, " rd_value"}, wb.rd_value, v.exp_val);
    end
    if (v.exp_fb) begin
      check({v.name, " fb.phy_id"}, {26'd0, fb.phy_id}, {26'd0, v.phy});
      check({v.name, " fb.value"}, fb.value, v.exp_val);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=expired required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   we_cnt;

    vecs.push_back(mkv("div 12/6",       DIV_OP_DIV,  32'd12,        32'd6,         1'b0, 1'b1, 6'd10, 32'd2,         1'b1, 33,  1'b1));
    vecs.push_back(mkv("rem -7/2",       DIV_OP_REM,  32'hFFFF_FFF9, 32'd2,         1'b0, 1'b1, 6'd11, 32'hFFFF_FFFF, 1'b1, 33,  1'b1));
    vecs.push_back(mkv("divu 7/0",       DIV_OP_DIVU, 32'd7,         32'd0,         1'b0, 1'b1, 6'd12, 32'hFFFF_FFFF, 1'b1, FP1, 1'b1));
    vecs.push_back(mkv("div min/-1",     DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 6'd13, 32'h8000_0000, 1'b1, FP1, 1'b1));
    vecs.push_back(mkv("rem min/-1",     DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 6'd14, 32'd0,         1'b1, FP1, 1'b1));
    vecs.push_back(mkv("rem -5/0",       DIV_OP_REM,  32'hFFFF_FFFB, 32'd0,         1'b0, 1'b1, 6'd15, 32'hFFFF_FFFB, 1'b1, FP1, 1'b1));
    vecs.push_back(mkv("divu 3/10",      DIV_OP_DIVU, 32'd3,         32'd10,        1'b0, 1'b1, 6'd16, 32'd0,         1'b1, FP1, 1'b1));
    vecs.push_back(mkv("remu 3/10",      DIV_OP_REMU, 32'd3,         32'd10,        1'b0, 1'b1, 6'd17, 32'd3,         1'b1, FP1, 1'b1));
    vecs.push_back(mkv("rem -3/10",      DIV_OP_REM,  32'hFFFF_FFFD, 32'd10,        1'b0, 1'b1, 6'd18, 32'hFFFF_FFFD, 1'b1, FP1, 1'b1));
    vecs.push_back(mkv("div -20/3",      DIV_OP_DIV,  32'hFFFF_FFEC, 32'd3,         1'b0, 1'b1, 6'd19, 32'hFFFF_FFFA, 1'b1, 33,  1'b1));
    vecs.push_back(mkv("rem 20/-3",      DIV_OP_REM,  32'd20,        32'hFFFF_FFFD, 1'b0, 1'b1, 6'd20, 32'd2,         1'b1, 33,  1'b1));
    vecs.push_back(mkv("div -7/-2",      DIV_OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 1'b1, 6'd21, 32'd3,         1'b1, 33,  1'b1));
    vecs.push_back(mkv("divu big/16",    DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd16,        1'b0, 1'b1, 6'd22, 32'h0FFF_FFFF, 1'b1, 33,  1'b1));
    vecs.push_back(mkv("div 100/7 nord", DIV_OP_DIV,  32'd100,       32'd7,         1'b0, 1'b0, 6'd23, 32'd14,        1'b1, 33,  1'b0));
    vecs.push_back(mkv("exception",      DIV_OP_DIV,  32'd12,        32'd6,         1'b1, 1'b1, 6'd24, 32'd0,         1'b0, 1,   1'b0));

    // Reset behaviour, with a valid head entry and an active commit flush.
    rst = 1'b1; valid1 = 1'b0; valid4 = 1'b0; in_pack = '0; commit = '0;
    repeat (2) @(negedge clk);
    in_pack = mk_pack(vecs[0]);
    valid1 = 1'b1;
    commit.enable = 1'b1; commit.flush = 1'b1;
    #1;
    check("reset pop", {31'd0, pop1}, 32'd0);
    check("reset we", {31'd0, we1}, 32'd0);
    check("reset busy", {31'd0, busy1}, 32'd0);
    check("reset fb.enable", {31'd0, fb1.enable}, 32'd0);
    check("reset flush follows commit", {31'd0, flush1}, 32'd1);
    commit = '0;
    #1;
    check("reset flush idle", {31'd0, flush1}, 32'd0);
    valid1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle wb.enable", {31'd0, wb1.enable}, 32'd0);

    // Table vectors back to back: each pop lands on the cycle after the previous DONE.
    foreach (vecs[i]) begin
      @(negedge clk);
      run_op(vecs[i], 1'b0);
    end

    // Commit flush in the middle of CALC drops the operation.
    @(negedge clk);
    in_pack = mk_pack(mkv("flushed", DIV_OP_DIV, 32'd12, 32'd6, 1'b0, 1'b1, 6'd30, 32'd2, 1'b1, 33, 1'b1));
    valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    repeat (10) @(negedge clk);
    check("flush pre busy", {31'd0, busy1}, 32'd1);
    commit.enable = 1'b1; commit.flush = 1'b1; valid1 = 1'b1;
    #1;
    check("flush wb_flush", {31'd0, flush1}, 32'd1);
    check("flush we", {31'd0, we1}, 32'd0);
    check("flush pop", {31'd0, pop1}, 32'd0);
    check("flush fb.enable", {31'd0, fb1.enable}, 32'd0);
    @(posedge clk);
    #1;
    commit = '0; valid1 = 1'b0;
    @(negedge clk);
    check("flush idle", {31'd0, busy1}, 32'd0);
    we_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (we1 === 1'b1) we_cnt++;
    end
    check("flush no writeback", we_cnt, 0);

    // Reset in the middle of CALC, then a fresh entry popped on the first IDLE cycle.
    @(negedge clk);
    in_pack = mk_pack(mkv("aborted", DIV_OP_DIV, 32'd12, 32'd6, 1'b0, 1'b1, 6'd31, 32'd2, 1'b1, 33, 1'b1));
    valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    repeat (5) @(negedge clk);
    v = mkv("after reset divu 100/10", DIV_OP_DIVU, 32'd100, 32'd10, 1'b0, 1'b1, 6'd40, 32'd10, 1'b1, 33, 1'b1);
    rst = 1'b1;
    in_pack = mk_pack(v);
    valid1 = 1'b1;
    #1;
    check("midcalc reset pop", {31'd0, pop1}, 32'd0);
    check("midcalc reset busy", {31'd0, busy1}, 32'd0);
    check("midcalc reset we", {31'd0, we1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(v, 1'b0);

    // Four quotient bits per cycle.
    @(negedge clk);
    run_op(mkv("bpc4 divu big/3", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b1, 6'd50, 32'h5555_5555, 1'b1, 9, 1'b1), 1'b1);
    @(negedge clk);
    run_op(mkv("bpc4 rem -7/2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 6'd51, 32'hFFFF_FFFF, 1'b1, 9, 1'b1), 1'b1);
    @(negedge clk);
    run_op(mkv("bpc4 divu 7/0", DIV_OP_DIVU, 32'd7, 32'd0, 1'b0, 1'b1, 6'd52, 32'hFFFF_FFFF, 1'b1, FP4, 1'b1), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/execute_div_mc.md
EXECUTE_DIV_MC -- requirements
Module: execute_div_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width in bits.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1, legal values 1, 2 and 4, which SHALL divide XLEN: quotient bits retired per iteration.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port issue_div_fifo_data_out, input, issue_execute_pack_t: head entry of the issue fifo.
REQ-006 SHALL have port issue_div_fifo_data_out_valid, input, 1 bit: head entry present.
REQ-007 SHALL have port issue_div_fifo_pop, output, 1 bit: consume the head entry this cycle.
REQ-008 SHALL have port div_wb_port_data_in, output, execute_wb_pack_t: result pack to writeback.
REQ-009 SHALL have port div_wb_port_we, output, 1 bit: writeback write strobe.
REQ-010 SHALL have port div_wb_port_flush, output, 1 bit: writeback flush request.
REQ-011 SHALL have port div_execute_channel_feedback_pack, output, execute_feedback_channel_t: bypass of enable, phy_id and value.
REQ-012 SHALL have port commit_feedback_pack, input, commit_feedback_pack_t: commit status, including enable and flush.
REQ-013 SHALL have port div_busy, output, 1 bit: high when the FSM is not IDLE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CALC and DONE.
REQ-015 SHALL define commit_flush as commit_feedback_pack.enable AND commit_feedback_pack.flush.
REQ-016 In IDLE, issue_div_fifo_pop SHALL equal issue_div_fifo_data_out_valid AND NOT commit_flush; pop SHALL be 0 in CALC and DONE.
REQ-017 On pop, the entry SHALL be latched; if enable=0, valid=0 or has_exception=1, the FSM SHALL go to DONE next cycle and pass the entry through without arithmetic.
REQ-018 On pop of a normal entry, the FSM SHALL go to CALC for exactly XLEN/BITS_PER_CYCLE cycles, then to DONE.
REQ-019 The iteration SHALL be restoring division on operand magnitudes; for div and rem, sign correction SHALL be applied in DONE.
REQ-020 sub_op.div_op SHALL select div, divu, rem or remu; rd_value SHALL be the quotient for div and divu, and the remainder for rem and remu.
REQ-021 Divide by zero SHALL give quotient all ones and remainder equal to the dividend.
REQ-022 Signed overflow (most negative value / -1) SHALL give quotient equal to the dividend and remainder 0.
REQ-023 In DONE, for exactly one cycle: div_wb_port_we SHALL be 1; div_wb_port_data_in SHALL carry the latched pack fields and rd_value; the FSM SHALL then return to IDLE.
REQ-024 In DONE, div_execute_channel_feedback_pack.enable SHALL be 1 only if valid, rd_enable and need_rename are all 1 and has_exception is 0; phy_id SHALL be rd_phy and value SHALL be rd_value.
REQ-025 Outside DONE, div_wb_port_we, div_wb_port_data_in.enable and feedback enable SHALL all be 0.
REQ-026 div_wb_port_flush SHALL equal commit_flush.
REQ-027 On commit_flush in any state, the FSM SHALL go to IDLE next cycle; the in-flight operation SHALL be dropped, and we, pop and feedback enable SHALL be 0 in that cycle.
REQ-028 No new entry SHALL be accepted in DONE; back-to-back throughput SHALL be one operation per (latency + 1) cycles.

Reset
REQ-029 While rst=1, the FSM SHALL be IDLE and the latched pack, iteration counter and partial remainder SHALL be 0.
REQ-030 While rst=1, pop, we, div_busy and feedback enable SHALL be 0; flush SHALL still follow REQ-026.
REQ-031 Reset asserted mid-CALC SHALL abort the operation with no writeback.

Configuration
REQ-032 Macro DIV_FAST_PATH_EN defined: divide by zero, signed overflow and unsigned |dividend| < |divisor| SHALL go from IDLE directly to DONE, with a latency of 1 cycle after pop.
REQ-033 Macro DIV_FAST_PATH_EN undefined: every normal entry SHALL take the full CALC duration; results SHALL be identical to the defined case.

Verification
REQ-034 XLEN=32, BITS_PER_CYCLE=1, div 12/6, rd_phy=10, rd_enable=1, need_rename=1 -> pop for 1 cycle; we=1 exactly 33 cycles after the pop edge; rd_value=2; feedback enable=1, phy_id=10, value=2.
REQ-035 Entry with has_exception=1 and exception_id=illegal_instruction -> we=1 one cycle after pop; has_exception=1 with matching exception_id; feedback enable=0.
REQ-036 rem -7/2 gives -1; divu 7/0 gives 0xFFFFFFFF; div 0x80000000/-1 gives 0x80000000 -> each checked under both macro settings, with fast-path latency of 1 cycle when DIV_FAST_PATH_EN is defined.
REQ-037 commit_flush asserted mid-CALC -> next cycle IDLE, we=0, pop=0, flush=1; no writeback ever occurs for the dropped entry.
REQ-038 BITS_PER_CYCLE=4, divu 0xFFFFFFFF/3 -> we 9 cycles after pop; rd_value=0x55555555.
REQ-039 rst asserted mid-CALC, then released with valid=1 -> no stale writeback; the new entry is popped on the first IDLE cycle.
